// File: rtl/sipp_dmem_arbiter_pkg.sv
// Shared definitions for the SIPP data-memory arbiter.
// Holds the read-owner encoding, default bus widths, the wait-counter width
// and a helper that decodes which requester owns a granted read.
package sipp_dmem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned WAIT_W     = 4;

  // Owner of the read granted in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  // Writes never produce read data, so only a granted read claims the tag.
  function automatic owner_e read_owner(input logic core_gnt, input logic core_we,
                                        input logic host_gnt, input logic host_we);
    owner_e own;
    own = OWN_NONE;
    if (core_gnt && !core_we) begin
      own = OWN_CORE;
    end else if (host_gnt && !host_we) begin
      own = OWN_HOST;
    end
    return own;
  endfunction

endpackage

// File: rtl/sipp_dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory array.
// Signals:
//   core_* / host_*  request (req, we, addr, wdata) and response (gnt, rvalid, rdata)
//   core_stall       core request refused this cycle
//   mem_*            single-port synchronous RAM strobe, write enable, address, data
// Modports:
//   slave  - the arbiter
//   master - the surrounding system (requesters and memory array)
interface sipp_dmem_arbiter_if #(
  parameter int unsigned ADDR_W = sipp_dmem_arbiter_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = sipp_dmem_arbiter_pkg::DEF_DATA_W
);

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/sipp_dmem_arbiter.sv
// SIPP data-memory arbiter: shares one single-port synchronous RAM between the
// processor core and the host port. Core has fixed priority; the host is never
// refused more than MAX_WAIT consecutive cycles. Read data returns one cycle
// after the grant, qualified by the owner's rvalid.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - sipp_dmem_arbiter_if.slave (core, host and memory sides)
// Grants, stall and the mem_* strobes are combinational from the requests;
// rvalid comes from the registered read tag.
module sipp_dmem_arbiter
  import sipp_dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sipp_dmem_arbiter_if.slave   bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic              core_gnt;
  logic              host_gnt;
  logic              host_at_limit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  owner_e            tag_q;
  owner_e            tag_d;
  logic              core_rvalid;
  logic              host_rvalid;

  // Fixed core priority, overridden once the host has waited MAX_WAIT cycles.
  always_comb begin
    host_at_limit = (wait_cnt_q == WAIT_LIMIT);
    host_gnt      = bus.host_req & (~bus.core_req | host_at_limit);
    core_gnt      = bus.core_req & ~host_gnt;
  end

  // Memory port steering; address/data follow the host when nobody is granted.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.host_addr;
    mem_wdata = bus.host_wdata;
    if (core_gnt) begin
      mem_we    = bus.core_we;
      mem_addr  = bus.core_addr;
      mem_wdata = bus.core_wdata;
    end else if (host_gnt) begin
      mem_we    = bus.host_we;
    end
  end

  // Host starvation counter: counts refused host cycles, never passes the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (host_gnt || !bus.host_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_LIMIT) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Read tag: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= OWN_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Read tag: next state is the owner of this cycle's granted read, if any.
  always_comb begin
    tag_d = OWN_NONE;
    tag_d = read_owner(core_gnt, bus.core_we, host_gnt, bus.host_we);
  end

  // Read tag: outputs. Gating with rst drops a read granted just before reset.
  always_comb begin
    core_rvalid = 1'b0;
    host_rvalid = 1'b0;
    if (!rst) begin
      core_rvalid = (tag_q == OWN_CORE);
      host_rvalid = (tag_q == OWN_HOST);
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.core_stall  = bus.core_req & ~core_gnt;
  assign bus.core_rvalid = core_rvalid;
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.host_gnt    = host_gnt;
  assign bus.host_rvalid = host_rvalid;
  assign bus.host_rdata  = bus.mem_rdata;
  assign bus.mem_en      = core_gnt | host_gnt;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;

endmodule

// File: tb/tb_sipp_dmem_arbiter.sv
// Scoreboard bench for sipp_dmem_arbiter: directed cycles push expected grants
// and expected read returns into queues; a negedge monitor pops and compares.
module tb_sipp_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sipp_dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  sipp_dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous single-port RAM model.
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  typedef struct {
    int          due;
    logic        cg;
    logic        hg;
    logic        st;
    logic        en;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wd;
  } gexp_t;

  typedef struct {
    int          due;
    logic [15:0] d;
  } rexp_t;

  gexp_t gq[$];
  rexp_t cq[$];
  rexp_t hq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus with its hand-computed expected grants and read return.
  task automatic step(input bit r,
                      input bit cr, input bit cw, input logic [7:0] ca, input logic [15:0] cd,
                      input bit hr, input bit hw, input logic [7:0] ha, input logic [15:0] hd,
                      input bit ecg, input bit ehg, input bit erv, input logic [15:0] erd);
    gexp_t g;
    rexp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    bus.core_req   = cr;
    bus.core_we    = cw;
    bus.core_addr  = ca;
    bus.core_wdata = cd;
    bus.host_req   = hr;
    bus.host_we    = hw;
    bus.host_addr  = ha;
    bus.host_wdata = hd;
    g.due  = cyc;
    g.cg   = ecg;
    g.hg   = ehg;
    g.st   = cr & ~ecg;
    g.en   = ecg | ehg;
    g.we   = ecg ? cw : (ehg ? hw : 1'b0);
    g.addr = ecg ? ca : ha;
    g.wd   = ecg ? cd : hd;
    gq.push_back(g);
    if (erv) begin
      e.due = cyc + 1;
      e.d   = erd;
      if (ecg) cq.push_back(e);
      else     hq.push_back(e);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h0000);
  endtask

  // Monitor: grant expectations in their cycle, rvalid/rdata every cycle.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t e;
    logic  ecv;
    logic  ehv;
    if (gq.size() > 0 && gq[0].due == cyc) begin
      g = gq.pop_front();
      chk("core_gnt", 32'(bus.core_gnt), 32'(g.cg));
      chk("host_gnt", 32'(bus.host_gnt), 32'(g.hg));
      chk("core_stall", 32'(bus.core_stall), 32'(g.st));
      chk("mem_en_we", 32'({bus.mem_en, bus.mem_we}), 32'({g.en, g.we}));
      if (g.en) chk("mem_addr_wdata", {8'h00, bus.mem_addr, bus.mem_wdata}, {8'h00, g.addr, g.wd});
    end
    ecv = (cq.size() > 0 && cq[0].due == cyc);
    ehv = (hq.size() > 0 && hq[0].due == cyc);
    chk("core_rvalid", 32'(bus.core_rvalid), 32'(ecv));
    chk("host_rvalid", 32'(bus.host_rvalid), 32'(ehv));
    if (ecv) begin
      e = cq.pop_front();
      chk("core_rdata", 32'(bus.core_rdata), 32'(e.d));
    end
    if (ehv) begin
      e = hq.pop_front();
      chk("host_rdata", 32'(bus.host_rdata), 32'(e.d));
    end
  end

  initial begin
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;

    // Reset: grants follow requests, no rvalid.
    step(1, 1, 1, 8'h40, 16'h1234, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h0000);
    step(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 16'h0000);
    idle();

    // Host write with core idle, then core reads it back.
    step(0, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h10, 16'hBEEF, 0, 1, 0, 16'h0000);
    step(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 16'hBEEF);
    idle();

    // Continuous core traffic: host wins in cycle 4 after four refusals.
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 8'(8'h20 + i), 16'(16'hC000 + i), 1, 0, 8'h10, 16'h0000, 1, 0, 0, 16'h0000);
    step(0, 1, 1, 8'h24, 16'hC004, 1, 0, 8'h10, 16'h0000, 0, 1, 1, 16'hBEEF);
    step(0, 1, 1, 8'h24, 16'hC004, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h0000);
    idle();

    // Alternating-owner reads, fully pipelined.
    step(0, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h01, 16'h1111, 0, 1, 0, 16'h0000);
    step(0, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h02, 16'h2222, 0, 1, 0, 16'h0000);
    step(0, 1, 0, 8'h01, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 16'h1111);
    step(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h02, 16'h0000, 0, 1, 1, 16'h2222);
    idle();
    idle();

    // Core write and host read to the same address in the same cycle.
    step(0, 1, 1, 8'h05, 16'h00AA, 1, 0, 8'h05, 16'h0000, 1, 0, 0, 16'h0000);
    step(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h05, 16'h0000, 0, 1, 1, 16'h00AA);
    idle();

    // Reset right after a core read grant: read dropped, wait count restarts.
    step(0, 1, 1, 8'h30, 16'h5555, 1, 0, 8'h01, 16'h0000, 1, 0, 0, 16'h0000);
    step(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h01, 16'h0000, 1, 0, 0, 16'h0000);
    step(1, 1, 0, 8'h11, 16'h0000, 1, 0, 8'h01, 16'h0000, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 8'(8'h31 + i), 16'(16'hD000 + i), 1, 0, 8'h01, 16'h0000, 1, 0, 0, 16'h0000);
    step(0, 1, 1, 8'h35, 16'hD004, 1, 0, 8'h01, 16'h0000, 0, 1, 1, 16'h1111);
    step(0, 1, 1, 8'h35, 16'hD004, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h0000);
    idle();

    // Host drops its request at wait count 3; the re-raised request waits the full limit.
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 8'(8'h40 + i), 16'(16'hE000 + i), 1, 0, 8'h02, 16'h0000, 1, 0, 0, 16'h0000);
    step(0, 1, 1, 8'h43, 16'hE003, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 8'(8'h44 + i), 16'(16'hE004 + i), 1, 0, 8'h02, 16'h0000, 1, 0, 0, 16'h0000);
    step(0, 1, 1, 8'h48, 16'hE008, 1, 0, 8'h02, 16'h0000, 0, 1, 1, 16'h2222);
    step(0, 1, 1, 8'h48, 16'hE008, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h0000);
    idle();
    idle();
    idle();

    @(posedge clk);
    #1;
    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("core_read_queue_drained", 32'(cq.size()), 32'd0);
    chk("host_read_queue_drained", 32'(hq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
